serial_tx_port: RTL

Responder side of the processor's byte-wide serial write port. Accepts bytes offered on the processor's serial data/write-enable outputs under a ready/write-enable handshake, buffers them in a small FIFO, and serialises them onto a UART TX line (8N1, LSB first). Sits between the processor core and the board-level UART pin, and provides the `serial_ready` signal the core polls before writing.

---
 rtl/serial_tx_port_if.sv | 18 +
 rtl/serial_tx_port.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_port_if.sv
// Byte-wide serial write handshake between the processor core and serial_tx_port.
interface serial_tx_port_if;
  logic [7:0] serial_in;
  logic       serial_wren_in;
  logic       serial_ready_out;

  modport master (
    output serial_in,
    output serial_wren_in,
    input  serial_ready_out
  );

  modport slave (
    input  serial_in,
    input  serial_wren_in,
    output serial_ready_out
  );
endinterface

// File: rtl/serial_tx_port.sv
// serial_tx_port: accepts processor bytes into a FIFO and sends them as UART 8N1 frames, LSB first.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_tx_port #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  serial_tx_port_if.slave             bus,
  output logic                        tx_out,
  output logic                        busy_out,
  output logic                        overflow_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_d;
  logic                busy_d;
  logic                baud_done;

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_d;
  logic [7:0]          head;
  logic                ready_c;
  logic                push;
  logic                pop;

`ifdef SERIAL_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // Ready never anticipates a same-cycle pop: it follows the registered count only.
  assign ready_c               = !reset && (count_q < CNT_FULL);
  assign bus.serial_ready_out  = ready_c;
  assign push                  = bus.serial_wren_in && ready_c;
  assign head                  = mem[rd_ptr_q];
  assign baud_done             = (baud_q == BAUD_LAST);
  assign fifo_count_out        = count_q;
  assign busy_d                = (state_d != S_IDLE) || (count_d != '0);

  // FIFO bookkeeping and sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q_hold();
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (bus.serial_wren_in && !ready_c) overflow_d = 1'b1;
  end

  function automatic logic overflow_q_hold();
    return overflow_out;
  endfunction

  // TX next-state and next-output logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_out;
    pop     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != S_IDLE) baud_d = baud_done ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^head;
`endif
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_done) begin
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_done) begin
          if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end

      S_PARITY: begin
        if (baud_done) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when more data is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = ^head;
`endif
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      tx_out       <= 1'b1;
      busy_out     <= 1'b0;
      overflow_out <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_out       <= tx_d;
      busy_out     <= busy_d;
      overflow_out <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= bus.serial_in;
  end

endmodule
